// File: rtl/combo_input_sequencer_if.sv
// Control and stimulus bundle of the combo input sequencer: switch/control
// inputs towards the sequencer and the registered stimulus it drives back.
interface combo_input_sequencer_if;
    logic [2:0] sw;
    logic       mode;
    logic       start;
    logic       stop;
    logic       a;
    logic       b;
    logic       c;
    logic [2:0] index;
    logic       busy;
    logic       sample;
    logic       done;

    modport master (
        output sw, mode, start, stop,
        input  a, b, c, index, busy, sample, done
    );

    modport slave (
        input  sw, mode, start, stop,
        output a, b, c, index, busy, sample, done
    );
endinterface

// File: rtl/combo_input_sequencer.sv
// Stimulus source for the 3-input gate example: debounced manual switches or an
// automatic sweep over all eight {a,b,c} combinations with a per-step dwell.
module combo_input_sequencer #(
    parameter int unsigned DWELL     = 4,
    parameter int unsigned DB_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    combo_input_sequencer_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
    localparam logic [7:0]  DB_RUN     = 8'(DB_CYCLES);

    logic [2:0]  sync1_q;
    logic [2:0]  sync2_q;
    logic [2:0]  last_q;
    logic [7:0]  run_q;
    logic [7:0]  run_d;
    logic [2:0]  db_q;
    logic [2:0]  db_d;

    state_e      state_q;
    state_e      state_d;
    logic [15:0] dwell_q;
    logic [15:0] dwell_d;
    logic [2:0]  index_q;
    logic [2:0]  index_d;
    logic [2:0]  abc_q;
    logic [2:0]  abc_d;
    logic        busy_q;
    logic        busy_d;
    logic        sample_q;
    logic        sample_d;
    logic        done_q;
    logic        done_d;

    // Debounce: run_d is the length of the current run of identical synchronized samples
    always_comb begin
        run_d = run_q;
        db_d  = db_q;
        if (sync2_q != last_q) begin
            run_d = 8'd1;
        end else if (run_q < DB_RUN) begin
            run_d = run_q + 8'd1;
        end else begin
            run_d = run_q;
        end
        if (run_d >= DB_RUN) begin
            db_d = sync2_q;
        end else begin
            db_d = db_q;
        end
    end

    // Two-flop switch synchronizer followed by the debounce registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            last_q  <= 3'b000;
            run_q   <= 8'd0;
            db_q    <= 3'b000;
        end else begin
            sync1_q <= bus.sw;
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
            run_q   <= run_d;
            db_q    <= db_d;
        end
    end

    // Sequencer next state; sample is precomputed so it is high while the dwell counter sits at its last value
    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        index_d  = index_q;
        abc_d    = abc_q;
        busy_d   = 1'b0;
        sample_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && bus.mode && !bus.stop) begin
                    state_d  = ST_SWEEP;
                    dwell_d  = 16'd0;
                    index_d  = 3'd0;
                    abc_d    = 3'b000;
                    busy_d   = 1'b1;
                    sample_d = (DWELL_LAST == 16'd0);
                end else if (!bus.mode) begin
                    abc_d = db_q;
                end else begin
                    abc_d = abc_q;
                end
            end
            ST_SWEEP: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (dwell_q == DWELL_LAST) begin
                    if (index_q == 3'd7) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        dwell_d  = 16'd0;
                        index_d  = index_q + 3'd1;
                        abc_d    = index_q + 3'd1;
                        busy_d   = 1'b1;
                        sample_d = (DWELL_LAST == 16'd0);
                    end
                end else begin
                    dwell_d  = dwell_q + 16'd1;
                    busy_d   = 1'b1;
                    sample_d = ((dwell_q + 16'd1) == DWELL_LAST);
                end
            end
            default: begin
                state_d = ST_IDLE;
                dwell_d = 16'd0;
                index_d = 3'd0;
                abc_d   = 3'b000;
            end
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            dwell_q  <= 16'd0;
            index_q  <= 3'd0;
            abc_q    <= 3'b000;
            busy_q   <= 1'b0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            index_q  <= index_d;
            abc_q    <= abc_d;
            busy_q   <= busy_d;
            sample_q <= sample_d;
            done_q   <= done_d;
        end
    end

    assign bus.a      = abc_q[2];
    assign bus.b      = abc_q[1];
    assign bus.c      = abc_q[0];
    assign bus.index  = index_q;
    assign bus.busy   = busy_q;
    assign bus.sample = sample_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_combo_input_sequencer.sv
// Self-checking bench: a DWELL=4 and a DWELL=1 sequencer share stimulus and are
// compared every cycle against a sweep-position / switch-history reference model.
module tb_combo_input_sequencer;

    localparam int DWELL0 = 4;
    localparam int DWELL1 = 1;
    localparam int DB     = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] sw;
    logic       mode;
    logic       start;
    logic       stop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    combo_input_sequencer_if bus0 ();
    combo_input_sequencer_if bus1 ();

    assign bus0.sw    = sw;
    assign bus0.mode  = mode;
    assign bus0.start = start;
    assign bus0.stop  = stop;
    assign bus1.sw    = sw;
    assign bus1.mode  = mode;
    assign bus1.start = start;
    assign bus1.stop  = stop;

    combo_input_sequencer #(.DWELL(DWELL0), .DB_CYCLES(DB)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    combo_input_sequencer #(.DWELL(DWELL1), .DB_CYCLES(DB)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // observed vector: {a,b,c}[8:6], index[5:3], busy[2], sample[1], done[0]
    logic [8:0] obs [2];
    assign obs[0] = {bus0.a, bus0.b, bus0.c, bus0.index, bus0.busy, bus0.sample, bus0.done};
    assign obs[1] = {bus1.a, bus1.b, bus1.c, bus1.index, bus1.busy, bus1.sample, bus1.done};

    // Reference model: sweep tracked as an elapsed-cycle position, debounce as a switch history window
    int         m_dwell [2] = '{DWELL0, DWELL1};
    bit         m_sweep [2];
    int         m_pos   [2];
    logic [2:0] m_abc   [2];
    logic [2:0] m_idx   [2];
    logic       m_busy  [2];
    logic       m_smp   [2];
    logic       m_done  [2];
    logic [2:0] m_db;
    logic [2:0] swq [$];

    function automatic logic [8:0] exp_vec(int m);
        return {m_abc[m], m_idx[m], m_busy[m], m_smp[m], m_done[m]};
    endfunction

    task automatic model_step();
        logic [2:0] db_now;
        bit         stable;
        db_now = m_db;
        if (reset) begin
            swq.delete();
            for (int i = 0; i < DB + 2; i++) swq.push_back(3'b000);
            m_db = 3'b000;
        end else begin
            swq.push_back(sw);
            if (swq.size() > DB + 2) void'(swq.pop_front());
            stable = 1'b1;
            for (int i = 1; i < DB; i++) if (swq[i] != swq[0]) stable = 1'b0;
            if (stable) m_db = swq[0];
        end
        for (int m = 0; m < 2; m++) begin
            m_smp[m]  = 1'b0;
            m_done[m] = 1'b0;
            if (reset) begin
                m_sweep[m] = 1'b0;
                m_pos[m]   = 0;
                m_abc[m]   = 3'b000;
                m_idx[m]   = 3'b000;
                m_busy[m]  = 1'b0;
            end else if (m_sweep[m]) begin
                if (stop) begin
                    m_sweep[m] = 1'b0;
                    m_busy[m]  = 1'b0;
                end else if (m_pos[m] == 8 * m_dwell[m] - 1) begin
                    m_sweep[m] = 1'b0;
                    m_busy[m]  = 1'b0;
                    m_done[m]  = 1'b1;
                end else begin
                    m_pos[m]++;
                    m_idx[m] = 3'(m_pos[m] / m_dwell[m]);
                    m_abc[m] = m_idx[m];
                    m_smp[m] = ((m_pos[m] % m_dwell[m]) == m_dwell[m] - 1);
                end
            end else if (start && mode && !stop) begin
                m_sweep[m] = 1'b1;
                m_pos[m]   = 0;
                m_idx[m]   = 3'b000;
                m_abc[m]   = 3'b000;
                m_busy[m]  = 1'b1;
                m_smp[m]   = (m_dwell[m] == 1);
            end else if (!mode) begin
                m_abc[m] = db_now;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; sw = 3'b111; mode = 1'b1; start = 1'b0; stop = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (j == 2) reset = 1'b0;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== 9'd0) begin
                    errors++;
                    $display("FAIL reset dut%0d step %0d: got %b expected %b", m, j, obs[m], 9'd0);
                end
            end
        end
    endtask

    task automatic test_full_sweep();
        logic [2:0] e_abc;
        logic [8:0] e_vec;
        int         n;
        mode = 1'b1;
        for (int j = 0; j < 5; j++) begin
            sw = 3'($urandom);
            tick();
        end
        start = 1'b1;
        for (int j = 1; j <= 36; j++) begin
            tick();
            start = 1'b0;
            sw = 3'($urandom);
            for (int m = 0; m < 2; m++) begin
                n = 8 * m_dwell[m];
                e_abc = (j <= n) ? 3'((j - 1) / m_dwell[m]) : 3'd7;
                e_vec = {e_abc, e_abc, 1'(j <= n), 1'(j <= n && (j % m_dwell[m]) == 0), 1'(j == n + 1)};
                checks++;
                if (obs[m] !== e_vec) begin
                    errors++;
                    $display("FAIL sweep_spec dut%0d j=%0d: got %b expected %b", m, j, obs[m], e_vec);
                end
                checks++;
                if (obs[m] !== exp_vec(m)) begin
                    errors++;
                    $display("FAIL sweep_model dut%0d j=%0d: got %b expected %b", m, j, obs[m], exp_vec(m));
                end
            end
        end
    endtask

    task automatic test_abort();
        mode = 1'b1;
        start = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            tick();
            start = (j == 5);
            mode  = (j == 6) ? 1'b0 : 1'b1;
            stop  = (j == 10);
            checks++;
            if (obs[0][2] !== 1'(j <= 10) || obs[0][0] !== 1'b0) begin
                errors++;
                $display("FAIL abort_busy j=%0d: got busy=%b done=%b expected busy=%b done=0", j, obs[0][2], obs[0][0], 1'(j <= 10));
            end
            if (j >= 11) begin
                checks++;
                if (obs[0][8:6] !== 3'b010 || obs[0][1] !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_hold j=%0d: got abc=%b sample=%b expected abc=010 sample=0", j, obs[0][8:6], obs[0][1]);
                end
            end
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== exp_vec(m)) begin
                    errors++;
                    $display("FAIL abort_model dut%0d j=%0d: got %b expected %b", m, j, obs[m], exp_vec(m));
                end
            end
        end
        stop = 1'b0;
    endtask

    task automatic test_manual_debounce();
        logic [2:0] e_abc;
        mode = 1'b0; sw = 3'b000;
        for (int j = 0; j < 15; j++) tick();
        sw = 3'b101;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (j == 14) sw = 3'b111;
            if (j == 19) sw = 3'b101;
            e_abc = (j >= 11) ? 3'b101 : 3'b000;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m][8:6] !== e_abc) begin
                    errors++;
                    $display("FAIL manual dut%0d j=%0d: got abc=%b expected %b", m, j, obs[m][8:6], e_abc);
                end
                checks++;
                if (obs[m] !== exp_vec(m)) begin
                    errors++;
                    $display("FAIL manual_model dut%0d j=%0d: got %b expected %b", m, j, obs[m], exp_vec(m));
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 2; k++) begin
            mode  = (k == 0);
            start = 1'b1;
            stop  = (k == 0);
            for (int j = 1; j <= 5; j++) begin
                tick();
                start = 1'b0;
                stop  = 1'b0;
                for (int m = 0; m < 2; m++) begin
                    checks++;
                    if (obs[m][2] !== 1'b0 || obs[m] !== exp_vec(m)) begin
                        errors++;
                        $display("FAIL no_sweep case%0d dut%0d j=%0d: got %b expected %b", k, m, j, obs[m], exp_vec(m));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [2:0] e_abc;
        mode = 1'b1;
        start = 1'b1;
        for (int j = 1; j <= 56; j++) begin
            tick();
            reset = (j == 15);
            start = (j == 20);
            if (j == 16) begin
                for (int m = 0; m < 2; m++) begin
                    checks++;
                    if (obs[m] !== 9'd0) begin
                        errors++;
                        $display("FAIL reset_mid dut%0d: got %b expected %b", m, obs[m], 9'd0);
                    end
                end
            end
            if (j >= 21 && j <= 52) begin
                e_abc = 3'((j - 21) / DWELL0);
                checks++;
                if (obs[0][8:6] !== e_abc || obs[0][2] !== 1'b1) begin
                    errors++;
                    $display("FAIL resweep j=%0d: got abc=%b busy=%b expected abc=%b busy=1", j, obs[0][8:6], obs[0][2], e_abc);
                end
            end
            checks++;
            if (obs[0][0] !== 1'(j == 53)) begin
                errors++;
                $display("FAIL resweep_done j=%0d: got %b expected %b", j, obs[0][0], 1'(j == 53));
            end
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== exp_vec(m)) begin
                    errors++;
                    $display("FAIL reset_mid_model dut%0d j=%0d: got %b expected %b", m, j, obs[m], exp_vec(m));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 3000; j++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 5) == 0) sw = 3'($urandom);
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== exp_vec(m)) begin
                    errors++;
                    $display("FAIL random dut%0d j=%0d: got %b expected %b", m, j, obs[m], exp_vec(m));
                end
            end
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_abort();
        test_manual_debounce();
        test_simultaneous();
        test_reset_mid_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
